// File: rtl/epmp_fetch_seq_if.sv
// Program-memory / execute-unit bus of the EPMP fetch sequencer.
// master = sequencer side, slave = memory + execute side.
interface epmp_fetch_seq_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] pm_addr;
    logic            pm_rd;
    logic [7:0]      pm_data;
    logic            IR_Load;
    logic [7:0]      op_arg;
    logic            exec_start;
    logic            exec_done;
    logic            jmp_req;
    logic [PC_W-1:0] jmp_addr;

    modport master (
        output pm_addr, pm_rd, IR_Load, op_arg, exec_start,
        input  pm_data, exec_done, jmp_req, jmp_addr
    );

    modport slave (
        input  pm_addr, pm_rd, IR_Load, op_arg, exec_start,
        output pm_data, exec_done, jmp_req, jmp_addr
    );
endinterface

// File: rtl/epmp_fetch_seq.sv
// EPMP instruction fetch sequencer: owns the PC, fetches opcode (+ operand), hands off to execute.
// Optional breakpoint/halt support is compiled in with EPMP_FETCH_BKPT_EN.
//
// state  | meaning
// S_IDLE | stopped, waiting for run
// S_F1   | opcode read strobe at pc, pc advances
// S_F2   | opcode returned, IR loads, bit 7 selects 2-byte format
// S_A1   | operand read strobe at pc, pc advances
// S_A2   | operand returned, captured into op_arg
// S_EX   | exec_start pulse; same-cycle exec_done finishes the instruction
// S_WAIT | waiting for exec_done
// S_HALT | breakpoint hit, waiting for bkpt_resume (EPMP_FETCH_BKPT_EN only)
module epmp_fetch_seq #(
    parameter int              PC_W      = 8,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    run_i,
`ifdef EPMP_FETCH_BKPT_EN
    input  logic [PC_W-1:0]         bkpt_addr_i,
    input  logic                    bkpt_arm_i,
    input  logic                    bkpt_resume_i,
    output logic                    bkpt_hit_o,
`endif
    epmp_fetch_seq_if.master        bus,
    output logic [PC_W-1:0]         pc_o,
    output logic                    busy_o
);

`ifdef EPMP_FETCH_BKPT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_F1, S_F2, S_A1, S_A2, S_EX, S_WAIT, S_HALT
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_F1, S_F2, S_A1, S_A2, S_EX, S_WAIT
    } state_e;
`endif

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      op_arg_q, op_arg_d;
    logic            pm_rd, ir_load, exec_start, end_instr;
`ifdef EPMP_FETCH_BKPT_EN
    logic            skip_q, skip_d;
    logic            bkpt_hit;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_VEC;
            op_arg_q <= 8'h00;
`ifdef EPMP_FETCH_BKPT_EN
            skip_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            op_arg_q <= op_arg_d;
`ifdef EPMP_FETCH_BKPT_EN
            skip_q   <= skip_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        op_arg_d   = op_arg_q;
        pm_rd      = 1'b0;
        ir_load    = 1'b0;
        exec_start = 1'b0;
        end_instr  = 1'b0;
`ifdef EPMP_FETCH_BKPT_EN
        skip_d     = skip_q;
        bkpt_hit   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (run_i) state_d = S_F1;
            end
            S_F1: begin
                pm_rd   = 1'b1;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_F2;
`ifdef EPMP_FETCH_BKPT_EN
                skip_d  = 1'b0;
`endif
            end
            S_F2: begin
                ir_load = 1'b1;
                state_d = bus.pm_data[7] ? S_A1 : S_EX;
            end
            S_A1: begin
                pm_rd   = 1'b1;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_A2;
            end
            S_A2: begin
                op_arg_d = bus.pm_data;
                state_d  = S_EX;
            end
            S_EX: begin
                exec_start = 1'b1;
                if (bus.exec_done) end_instr = 1'b1;
                else               state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (bus.exec_done) end_instr = 1'b1;
            end
`ifdef EPMP_FETCH_BKPT_EN
            S_HALT: begin
                bkpt_hit = 1'b1;
                if (bkpt_resume_i) begin
                    skip_d  = 1'b1;
                    state_d = S_F1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (end_instr) begin
            if (bus.jmp_req) pc_d = bus.jmp_addr;
            state_d = run_i ? S_F1 : S_IDLE;
        end

`ifdef EPMP_FETCH_BKPT_EN
        // pc_d is the address the upcoming fetch will use (jump already applied)
        if ((state_d == S_F1) && (state_q != S_HALT) && bkpt_arm_i &&
            (pc_d == bkpt_addr_i) && !skip_q) begin
            state_d = S_HALT;
        end
`endif
    end

    // Strobes are masked while reset is held so nothing fires on the reset edge
    assign bus.pm_rd      = pm_rd & ~rst_i;
    assign bus.IR_Load    = ir_load & ~rst_i;
    assign bus.exec_start = exec_start & ~rst_i;
    assign bus.pm_addr    = pc_q;
    assign bus.op_arg     = op_arg_q;
    assign pc_o           = pc_q;
    assign busy_o         = (state_q != S_IDLE);
`ifdef EPMP_FETCH_BKPT_EN
    assign bkpt_hit_o     = bkpt_hit & ~rst_i;
`endif

endmodule

// File: tb/tb_epmp_fetch_seq.sv
// Scoreboard bench for epmp_fetch_seq: stimulus pushes expected fetch addresses, opcodes and
// execute hand-offs; a negedge monitor pops and compares whenever the DUT strobes.
module tb_epmp_fetch_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [7:0] pc;
    logic       busy;
    logic [7:0] mem [256];
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    int         last_ex = 0;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] op;
        int         gap;
    } ex_t;

    logic [7:0] exp_addr [$];
    logic [7:0] exp_ir   [$];
    ex_t        exp_ex   [$];

    epmp_fetch_seq_if #(.PC_W(8)) bus ();

`ifdef EPMP_FETCH_BKPT_EN
    logic [7:0] bkpt_addr = 8'h00;
    logic       bkpt_arm = 1'b0;
    logic       bkpt_resume = 1'b0;
    logic       bkpt_hit;
`endif

    epmp_fetch_seq #(.PC_W(8), .RESET_VEC(8'h00)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .run_i         (run),
`ifdef EPMP_FETCH_BKPT_EN
        .bkpt_addr_i   (bkpt_addr),
        .bkpt_arm_i    (bkpt_arm),
        .bkpt_resume_i (bkpt_resume),
        .bkpt_hit_o    (bkpt_hit),
`endif
        .bus           (bus),
        .pc_o          (pc),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Program memory: one-cycle read latency
    always @(posedge clk) if (bus.pm_rd) bus.pm_data <= mem[bus.pm_addr];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        ex_t        e;
        logic [7:0] v;
        if (!rst) begin
            if (bus.pm_rd) begin
                if (exp_addr.size() == 0) fail_now("pm_rd unexpected");
                else begin
                    v = exp_addr.pop_front();
                    check("pm_addr", int'(bus.pm_addr), int'(v));
                end
            end
            if (bus.IR_Load) begin
                if (exp_ir.size() == 0) fail_now("IR_Load unexpected");
                else begin
                    v = exp_ir.pop_front();
                    check("IR opcode", int'(bus.pm_data), int'(v));
                end
            end
            if (bus.exec_start) begin
                if (exp_ex.size() == 0) fail_now("exec_start unexpected");
                else begin
                    e = exp_ex.pop_front();
                    check("pc at exec_start", int'(pc), int'(e.pc));
                    check("op_arg at exec_start", int'(bus.op_arg), int'(e.op));
                    if (e.gap != 0) check("instr cycles", cyc - last_ex, e.gap);
                end
                last_ex = cyc;
            end
        end
    end

    task automatic push(input logic [7:0] addr, input logic [7:0] ir);
        exp_addr.push_back(addr);
        if (ir != 8'hxx) exp_ir.push_back(ir);
    endtask

    task automatic push_ex(input logic [7:0] p, input logic [7:0] op, input int gap);
        ex_t e;
        e.pc = p; e.op = op; e.gap = gap;
        exp_ex.push_back(e);
    endtask

    task automatic wait_ex(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.exec_start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now({tag, " exec_start timeout"});
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        run = 1'b0;
        bus.exec_done = 1'b0;
        bus.jmp_req = 1'b0;
        bus.jmp_addr = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus.pm_data = 8'h00;
        apply_reset();

        // Reset state
        check("reset busy", int'(busy), 0);
        check("reset pc", int'(pc), 0);
        check("reset pm_addr", int'(bus.pm_addr), 0);
        check("reset op_arg", int'(bus.op_arg), 0);
        check("reset pm_rd", int'(bus.pm_rd), 0);
        check("reset IR_Load", int'(bus.IR_Load), 0);
        check("reset exec_start", int'(bus.exec_start), 0);

        // Continuous run, exec_done tied high: 1-byte and 2-byte opcodes
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h01;
        mem[4] = 8'h85; mem[5] = 8'h3C; mem[6] = 8'h07;
        push(8'h00, 8'h12); push_ex(8'h01, 8'h00, 0);
        push(8'h01, 8'h34); push_ex(8'h02, 8'h00, 3);
        push(8'h02, 8'h56); push_ex(8'h03, 8'h00, 3);
        push(8'h03, 8'h01); push_ex(8'h04, 8'h00, 3);
        push(8'h04, 8'h85); push(8'h05, 8'hxx); push_ex(8'h06, 8'h3C, 5);
        push(8'h06, 8'h07); push_ex(8'h07, 8'h3C, 3);
        bus.exec_done = 1'b1;
        run = 1'b1;
        for (int k = 0; k < 6; k++) wait_ex("runA");
        run = 1'b0;
        @(negedge clk);
        check("runA idle busy", int'(busy), 0);
        check("runA idle pc", int'(pc), 8'h07);

        // Long execute, ignored jmp_req while waiting, then jump to F0
        apply_reset();
        mem[0] = 8'h22; mem[8'hF0] = 8'h11;
        push(8'h00, 8'h22); push_ex(8'h01, 8'h00, 0);
        push(8'hF0, 8'h11); push_ex(8'hF1, 8'h00, 0);
        run = 1'b1;
        wait_ex("waitB");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) begin bus.jmp_req = 1'b1; bus.jmp_addr = 8'h80; end
            if (i == 2) bus.jmp_req = 1'b0;
            check("wait pm_rd", int'(bus.pm_rd), 0);
            check("wait pc", int'(pc), 8'h01);
            check("wait busy", int'(busy), 1);
        end
        bus.exec_done = 1'b1; bus.jmp_req = 1'b1; bus.jmp_addr = 8'hF0;
        @(negedge clk);
        bus.exec_done = 1'b0; bus.jmp_req = 1'b0; run = 1'b0;
        wait_ex("jumpB");
        bus.exec_done = 1'b1;
        @(negedge clk);
        check("jumpB idle busy", int'(busy), 0);
        check("jumpB idle pc", int'(pc), 8'hF1);
        bus.exec_done = 1'b0;

        // 2-byte opcode at FF: operand wraps to 00; run dropped during operand fetch
        apply_reset();
        mem[0] = 8'h01; mem[8'hFF] = 8'h9A;
        push(8'h00, 8'h01); push_ex(8'h01, 8'h00, 0);
        push(8'hFF, 8'h9A); push(8'h00, 8'hxx); push_ex(8'h01, 8'h01, 5);
        bus.exec_done = 1'b1; bus.jmp_req = 1'b1; bus.jmp_addr = 8'hFF;
        run = 1'b1;
        wait_ex("wrapC first");
        @(negedge clk);
        bus.jmp_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.pm_rd && bus.pm_addr == 8'h00) begin seen = 1'b1; break; end
        end
        if (!seen) fail_now("wrapC operand fetch timeout");
        run = 1'b0;
        wait_ex("wrapC second");
        @(negedge clk);
        check("wrapC idle busy", int'(busy), 0);
        check("wrapC idle pc", int'(pc), 8'h01);

        // Reset while waiting on execute aborts the instruction
        apply_reset();
        mem[0] = 8'h22;
        push(8'h00, 8'h22); push_ex(8'h01, 8'h00, 0);
        run = 1'b1;
        wait_ex("rstD");
        run = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstD busy", int'(busy), 0);
        check("rstD pc", int'(pc), 0);
        check("rstD pm_rd", int'(bus.pm_rd), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rstD exec_start", int'(bus.exec_start), 0);
        check("rstD stays idle", int'(busy), 0);

`ifdef EPMP_FETCH_BKPT_EN
        // Breakpoint at 02: halt without fetching, resume fetches 02 once and runs on
        apply_reset();
        mem[0] = 8'h01; mem[1] = 8'h03; mem[2] = 8'h04; mem[3] = 8'h05;
        push(8'h00, 8'h01); push_ex(8'h01, 8'h00, 0);
        push(8'h01, 8'h03); push_ex(8'h02, 8'h00, 3);
        push(8'h02, 8'h04); push_ex(8'h03, 8'h00, 0);
        push(8'h03, 8'h05); push_ex(8'h04, 8'h00, 3);
        bkpt_addr = 8'h02; bkpt_arm = 1'b1;
        bus.exec_done = 1'b1;
        run = 1'b1;
        wait_ex("bkpt first");
        wait_ex("bkpt second");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halt bkpt_hit", int'(bkpt_hit), 1);
            check("halt pm_rd", int'(bus.pm_rd), 0);
            check("halt busy", int'(busy), 1);
        end
        bkpt_resume = 1'b1;
        @(negedge clk);
        bkpt_resume = 1'b0;
        check("resume bkpt_hit", int'(bkpt_hit), 0);
        wait_ex("bkpt third");
        run = 1'b0;
        wait_ex("bkpt fourth");
        @(negedge clk);
        check("bkpt idle busy", int'(busy), 0);
        bkpt_arm = 1'b0;
        bus.exec_done = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("leftover pm_addr expectations", exp_addr.size(), 0);
        check("leftover IR expectations", exp_ir.size(), 0);
        check("leftover exec expectations", exp_ex.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
